// File: rtl/ioctl_rom_loader.sv
// ioctl_rom_loader
//
// Buffers HPS ioctl download words into a small FIFO and replays them as
// memory write requests, tracking which ROM slots have finished loading.
//
// Parameters:
//   DATA_WIDTH - ioctl word width (8 or 16)
//   ADDR_WIDTH - ioctl byte-address width
//   SLOTS      - number of loadable ROM slots (1..8)
//   FIFO_DEPTH - write-buffer depth (power of 2, 4..16)
//
// Ports:
//   clk_sys_131_072 - sole clock
//   reset           - synchronous, active-high reset
//   ioctl_download  - download in progress
//   ioctl_index     - target slot (bits [2:0] used)
//   ioctl_wr        - one-cycle data strobe
//   ioctl_addr      - byte address of ioctl_dout
//   ioctl_dout      - download data
//   ioctl_wait      - backpressure to the HPS (FIFO nearly full)
//   mem_wr          - write request (FIFO non-empty)
//   mem_addr        - word address of the FIFO head
//   mem_data        - data of the FIFO head
//   mem_slot        - slot of the FIFO head
//   mem_ready       - memory accepted the head this cycle
//   loaded          - per-slot load-complete flags
//   core_hold       - keeps the core in reset until slot 0 is loaded and idle
//   err_overflow    - sticky: a write arrived with the FIFO full and was dropped
//   checksum        - 16-bit running sum of the last load
//
// Optional feature: define LOADER_CHECKSUM_EN to build the checksum adder;
// otherwise checksum is tied to zero.

module ioctl_rom_loader #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 25,
    parameter int unsigned SLOTS      = 4,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                  clk_sys_131_072,
    input  logic                  reset,
    input  logic                  ioctl_download,
    input  logic [7:0]            ioctl_index,
    input  logic                  ioctl_wr,
    input  logic [ADDR_WIDTH-1:0] ioctl_addr,
    input  logic [DATA_WIDTH-1:0] ioctl_dout,
    output logic                  ioctl_wait,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic [2:0]            mem_slot,
    input  logic                  mem_ready,
    output logic [SLOTS-1:0]      loaded,
    output logic                  core_hold,
    output logic                  err_overflow,
    output logic [15:0]           checksum
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [1:0] {StIdle, StLoad, StDrain} state_e;

    state_e            state_q, state_d;
    logic              dl_q;
    logic [2:0]        slot_q, slot_d;
    logic              pend_q, pend_d;
    logic [2:0]        pend_slot_q, pend_slot_d;
    logic [SLOTS-1:0]  loaded_q, loaded_d;
    logic              err_q, err_d;
    logic              load_start;

    logic [ADDR_WIDTH-1:0] fifo_addr [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic [2:0]            fifo_slot [FIFO_DEPTH];
    logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]       count_q;

    logic                  dl_rise, slot_ok, fifo_empty, fifo_full;
    logic                  push_req, push, pop;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic                  unused_index_hi;

    assign unused_index_hi = ^ioctl_index[7:3];

    generate
        if (DATA_WIDTH == 16) begin : g_addr16
            logic unused_addr_lsb;
            assign unused_addr_lsb = ioctl_addr[0];
            assign word_addr = ioctl_addr >> 1;
        end else begin : g_addr8
            assign word_addr = ioctl_addr;
        end
    endgenerate

    assign dl_rise    = ioctl_download & ~dl_q;
    assign slot_ok    = 32'(slot_q) < SLOTS;
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CntW'(FIFO_DEPTH));
    assign pop        = ~fifo_empty & mem_ready;
    assign push_req   = (state_q == StLoad) & ioctl_wr & slot_ok;
    // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
    assign push       = push_req & (~fifo_full | pop);

    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        pend_d      = pend_q;
        pend_slot_d = pend_slot_q;
        loaded_d    = loaded_q;
        err_d       = err_q | (push_req & ~push);
        load_start  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (dl_rise) begin
                    state_d    = StLoad;
                    slot_d     = ioctl_index[2:0];
                    load_start = 1'b1;
                end
            end
            StLoad: begin
                if (!ioctl_download) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (fifo_empty) begin
                    for (int i = 0; i < SLOTS; i++) begin
                        if (slot_q == 3'(i)) begin
                            loaded_d[i] = 1'b1;
                        end
                    end
                    // A download that started while draining begins once the old one is out.
                    if (pend_q || dl_rise) begin
                        state_d    = StLoad;
                        slot_d     = dl_rise ? ioctl_index[2:0] : pend_slot_q;
                        pend_d     = 1'b0;
                        load_start = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (dl_rise) begin
                    pend_d      = 1'b1;
                    pend_slot_d = ioctl_index[2:0];
                end
            end
            default: state_d = StIdle;
        endcase
        // Applied last so a reload of the slot just completed still invalidates it.
        if (load_start) begin
            for (int i = 0; i < SLOTS; i++) begin
                if (slot_d == 3'(i)) begin
                    loaded_d[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_sys_131_072) begin
        if (reset) begin
            state_q     <= StIdle;
            dl_q        <= 1'b0;
            slot_q      <= '0;
            pend_q      <= 1'b0;
            pend_slot_q <= '0;
            loaded_q    <= '0;
            err_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            dl_q        <= ioctl_download;
            slot_q      <= slot_d;
            pend_q      <= pend_d;
            pend_slot_q <= pend_slot_d;
            loaded_q    <= loaded_d;
            err_q       <= err_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CntW'(push) - CntW'(pop);
        end
    end

    // Storage needs no reset: outputs are masked while the FIFO is empty.
    always_ff @(posedge clk_sys_131_072) begin
        if (push) begin
            fifo_addr[wr_ptr_q] <= word_addr;
            fifo_data[wr_ptr_q] <= ioctl_dout;
            fifo_slot[wr_ptr_q] <= slot_q;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [15:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (load_start) begin
            csum_d = '0;
        end else if (push) begin
            csum_d = csum_q + 16'(ioctl_dout);
        end
    end

    always_ff @(posedge clk_sys_131_072) begin
        if (reset) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign checksum = csum_q;
`else
    assign checksum = '0;
`endif

    assign mem_wr       = ~fifo_empty;
    assign mem_addr     = fifo_empty ? '0 : fifo_addr[rd_ptr_q];
    assign mem_data     = fifo_empty ? '0 : fifo_data[rd_ptr_q];
    assign mem_slot     = fifo_empty ? '0 : fifo_slot[rd_ptr_q];
    assign ioctl_wait   = (count_q >= CntW'(FIFO_DEPTH - 2));
    assign loaded       = loaded_q;
    assign err_overflow = err_q;
    assign core_hold    = ~loaded_q[0] | (state_q != StIdle);

endmodule
